// File: rtl/cnt_step_sequencer.sv
// Step sequencer for the free-running counter: enables the counter, counts end-of-count
// edges, and pauses after each programmed batch to hand a step index to a consumer.
module cnt_step_sequencer #(
    parameter int WAIT_W = 4,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WAIT_W-1:0] wait_cfg_i,
    input  logic [STEP_W-1:0] num_steps_i,
    input  logic              end_cnt_i,
    output logic              flag_cnt_o,
    output logic              step_vld_o,
    output logic [STEP_W-1:0] step_idx_o,
    input  logic              step_ack_i,
    output logic [WAIT_W-1:0] pulse_cnt_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic [WAIT_W-1:0] pulse_nxt_s;
    logic [STEP_W-1:0] steps_r;
    logic [STEP_W-1:0] steps_nxt_s;
    logic [STEP_W-1:0] idx_nxt_s;
    logic              end_q_r;
    logic              evt_s;

    assign evt_s = end_cnt_i & ~end_q_r;

    // Next-state, counter and config update logic
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        steps_nxt_s = steps_r;
        pulse_nxt_s = pulse_cnt_o;
        idx_nxt_s   = step_idx_o;
        case (state_r)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    wait_nxt_s  = (wait_cfg_i == {WAIT_W{1'b0}}) ? WAIT_W'(1) : wait_cfg_i;
                    steps_nxt_s = num_steps_i;
                    pulse_nxt_s = {WAIT_W{1'b0}};
                    idx_nxt_s   = {STEP_W{1'b0}};
                    state_nxt_s = (num_steps_i == {STEP_W{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                    pulse_nxt_s = {WAIT_W{1'b0}};
                    idx_nxt_s   = {STEP_W{1'b0}};
                end else if (evt_s) begin
                    // Terminal compare keeps pulse_cnt bounded by wait-1, so it never wraps
                    if (pulse_cnt_o == wait_r - WAIT_W'(1)) begin
                        pulse_nxt_s = {WAIT_W{1'b0}};
                        state_nxt_s = ST_STEP;
                    end else begin
                        pulse_nxt_s = pulse_cnt_o + WAIT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                    pulse_nxt_s = {WAIT_W{1'b0}};
                    idx_nxt_s   = {STEP_W{1'b0}};
                end else if (step_ack_i) begin
                    if (step_idx_o == steps_r - STEP_W'(1)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        idx_nxt_s   = step_idx_o + STEP_W'(1);
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_DONE: begin
                if (abort_i) begin
                    pulse_nxt_s = {WAIT_W{1'b0}};
                    idx_nxt_s   = {STEP_W{1'b0}};
                end else begin
                    pulse_nxt_s = pulse_cnt_o;
                end
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, config, counters and output registers; outputs decoded from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wait_r      <= {WAIT_W{1'b0}};
            steps_r     <= {STEP_W{1'b0}};
            end_q_r     <= 1'b0;
            pulse_cnt_o <= {WAIT_W{1'b0}};
            step_idx_o  <= {STEP_W{1'b0}};
            flag_cnt_o  <= 1'b0;
            step_vld_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_r      <= wait_nxt_s;
            steps_r     <= steps_nxt_s;
            end_q_r     <= end_cnt_i;
            pulse_cnt_o <= pulse_nxt_s;
            step_idx_o  <= idx_nxt_s;
            flag_cnt_o  <= (state_nxt_s == ST_RUN);
            step_vld_o  <= (state_nxt_s == ST_STEP);
            busy_o      <= (state_nxt_s != ST_IDLE);
            done_o      <= (state_nxt_s == ST_DONE);
        end
    end

endmodule
